// File: rtl/texture_stream_pkg.sv
// Shared types, constants and the beat-count helper used by the texture stream blocks.
package texture_stream_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

    localparam int TEXEL_WIDTH  = 16;
    localparam int MAX_TEX_LOG2 = 8;
    localparam int BEAT_CNT_W   = 2 * MAX_TEX_LOG2 + 1;

    // Size fields above MAX_TEX_LOG2 are clamped; tiny textures still emit one beat.
    function automatic logic [BEAT_CNT_W-1:0] calc_beats(input logic [3:0] w,
                                                         input logic [3:0] h,
                                                         input int         stream_width);
        int lw;
        int lh;
        int n;
        lw = (int'(w) > MAX_TEX_LOG2) ? MAX_TEX_LOG2 : int'(w);
        lh = (int'(h) > MAX_TEX_LOG2) ? MAX_TEX_LOG2 : int'(h);
        n  = ((1 << (lw + lh)) * TEXEL_WIDTH) / stream_width;
        if (n < 1) n = 1;
        return n[BEAT_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/stream_sync_fifo.sv
// Synchronous FIFO with a registered head entry and an occupancy count.
module stream_sync_fifo #(
    parameter int DATA_W = 33,
    parameter int DEPTH  = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_data,
    input  logic                       i_pop,
    output logic                       o_valid,
    output logic [DATA_W-1:0]          o_data,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [DATA_W-1:0]  r_head;
    logic               r_head_vld;
    logic [PTR_W:0]     r_count;

    logic w_pop;
    logic w_ring_empty;
    logic w_push_head;
    logic w_push_ring;
    logic w_refill;

    // Entries behind the head live in a ring that never holds more than DEPTH-1 items,
    // so equal pointers always mean empty.
    assign w_pop        = i_pop && r_head_vld;
    assign w_ring_empty = (r_wr_ptr == r_rd_ptr);
    assign w_push_head  = i_push && (!r_head_vld || (w_pop && w_ring_empty));
    assign w_push_ring  = i_push && !w_push_head;
    assign w_refill     = w_pop && !w_ring_empty;

    always_ff @(posedge i_clk) begin
        if (w_push_ring) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_head     <= '0;
            r_head_vld <= 1'b0;
            r_count    <= '0;
        end else begin
            if (w_push_ring) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_push_head) begin
                r_head     <= i_data;
                r_head_vld <= 1'b1;
            end else if (w_refill) begin
                r_head   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end else if (w_pop) begin
                r_head_vld <= 1'b0;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = r_head_vld;
    assign o_data  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/texture_stream_tx.sv
// Streams a stored texture from word-addressed memory out as AXI-Stream beats.
// Optional TEXTURE_STREAM_TX_CHECKSUM_EN adds a 32-bit sum of all accepted beats.
module texture_stream_tx
    import texture_stream_pkg::*;
#(
    parameter int STREAM_WIDTH = 32,
    parameter int ADDR_WIDTH   = 17,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                     aclk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    startAddr,
    input  logic [3:0]               textureSizeWidth,
    input  logic [3:0]               textureSizeHeight,
    output logic                     busy,
    output logic                     done,
    output logic                     m_mem_rd,
    output logic [ADDR_WIDTH-1:0]    m_mem_addr,
    input  logic [STREAM_WIDTH-1:0]  m_mem_rdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [STREAM_WIDTH-1:0]  m_axis_tdata
`ifdef TEXTURE_STREAM_TX_CHECKSUM_EN
    ,output logic [31:0]             checksum
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [BEAT_CNT_W-1:0]   r_beats;
    logic [BEAT_CNT_W-1:0]   r_rd_idx;
    logic                    r_rd_p1;
    logic                    r_last_p1;
    logic                    r_done;

    logic                    w_fifo_vld;
    logic [STREAM_WIDTH:0]   w_fifo_data;
    logic [CNT_W-1:0]        w_fifo_count;
    logic                    w_accept;
    logic                    w_credit;
    logic                    w_rd;
    logic                    w_rd_last;
    logic                    w_hs;
    logic                    w_hs_last;

    assign w_accept  = (r_state == IDLE) && start;
    assign w_credit  = (w_fifo_count + {{(CNT_W-1){1'b0}}, r_rd_p1}) < CNT_W'(FIFO_DEPTH);
    assign w_rd      = (r_state == STREAM) && w_credit;
    assign w_rd_last = (r_rd_idx == r_beats - 1'b1);
    assign w_hs      = w_fifo_vld && m_axis_tready;
    assign w_hs_last = w_hs && w_fifo_data[STREAM_WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)             w_state_nxt = STREAM;
            STREAM:  if (w_rd && w_rd_last) w_state_nxt = DRAIN;
            DRAIN:   if (w_hs_last)         w_state_nxt = IDLE;
            default:                        w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Stage p0: read issue; stage p1: memory data returns and is pushed.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_addr   <= '0;
            r_rd_idx <= '0;
            r_rd_p1  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_rd_p1 <= w_rd;
            r_done  <= (r_state == DRAIN) && w_hs_last;
            if (w_accept) begin
                r_addr   <= startAddr;
                r_rd_idx <= '0;
            end else if (w_rd) begin
                r_addr   <= r_addr + 1'b1;
                r_rd_idx <= r_rd_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_accept) r_beats <= calc_beats(textureSizeWidth, textureSizeHeight, STREAM_WIDTH);
        r_last_p1 <= w_rd && w_rd_last;
    end

    stream_sync_fifo #(
        .DATA_W (STREAM_WIDTH + 1),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (aclk),
        .i_rst   (reset),
        .i_push  (r_rd_p1),
        .i_data  ({r_last_p1, m_mem_rdata}),
        .i_pop   (m_axis_tready),
        .o_valid (w_fifo_vld),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_count)
    );

    assign busy          = (r_state != IDLE);
    assign done          = r_done;
    assign m_mem_rd      = w_rd;
    assign m_mem_addr    = r_addr;
    assign m_axis_tvalid = w_fifo_vld;
    assign m_axis_tlast  = w_fifo_data[STREAM_WIDTH];
    assign m_axis_tdata  = w_fifo_data[STREAM_WIDTH-1:0];

`ifdef TEXTURE_STREAM_TX_CHECKSUM_EN
    localparam int LANES = (STREAM_WIDTH + 31) / 32;

    logic [31:0] r_checksum;

    function automatic logic [31:0] fold_lanes(input logic [STREAM_WIDTH-1:0] d);
        logic [LANES*32-1:0] pad;
        logic [31:0]         s;
        pad = '0;
        pad[STREAM_WIDTH-1:0] = d;
        s = '0;
        for (int i = 0; i < LANES; i++) s = s + pad[i*32 +: 32];
        return s;
    endfunction

    always_ff @(posedge aclk) begin
        if (reset || w_accept) r_checksum <= '0;
        else if (w_hs)         r_checksum <= r_checksum + fold_lanes(m_axis_tdata);
    end

    assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_texture_stream_tx.sv
// Scoreboard bench for texture_stream_tx: expected reads/beats queued at start, checked by a monitor.
module tb_texture_stream_tx;

    localparam int SW = 32;
    localparam int AW = 17;
    localparam int FD = 4;

    logic          aclk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] startAddr;
    logic [3:0]    tw;
    logic [3:0]    th;
    logic          busy;
    logic          done;
    logic          m_mem_rd;
    logic [AW-1:0] m_mem_addr;
    logic [SW-1:0] m_mem_rdata;
    logic          tvalid;
    logic          tready = 1'b1;
    logic          tlast;
    logic [SW-1:0] tdata;
`ifdef TEXTURE_STREAM_TX_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    always #5 aclk = ~aclk;

    texture_stream_tx #(.STREAM_WIDTH(SW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
        .aclk              (aclk),
        .reset             (reset),
        .start             (start),
        .startAddr         (startAddr),
        .textureSizeWidth  (tw),
        .textureSizeHeight (th),
        .busy              (busy),
        .done              (done),
        .m_mem_rd          (m_mem_rd),
        .m_mem_addr        (m_mem_addr),
        .m_mem_rdata       (m_mem_rdata),
        .m_axis_tvalid     (tvalid),
        .m_axis_tready     (tready),
        .m_axis_tlast      (tlast),
        .m_axis_tdata      (tdata)
`ifdef TEXTURE_STREAM_TX_CHECKSUM_EN
        ,.checksum         (checksum)
`endif
    );

    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    logic [SW:0]   exp_q[$];
    logic [AW-1:0] addr_q[$];
    int            rd_issued = 0;
    int            acc = 0;
    int            last_tl_cyc = -10;
    int            tv_rise = -1;
    bit            prev_stall = 0;
    bit            prev_tv = 0;
    logic [SW:0]   prev_beat = '0;
    bit            small_mode = 0;
    logic [AW-1:0] small_base = '0;
    bit            tr_rand = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    function automatic logic [SW-1:0] mem_word(input logic [AW-1:0] a);
        if (small_mode) return SW'(a - small_base) + 32'd1;
        return {8'hA5, 7'h00, a};
    endfunction

    always @(posedge aclk) m_mem_rdata <= m_mem_rd ? mem_word(m_mem_addr) : 32'hDEADBEEF;

    always @(posedge aclk) begin
        #2;
        tready = tr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: reads, beats, stall stability, credit limit and done placement.
    always @(negedge aclk) begin : mon
        logic [SW:0]   e;
        logic [AW-1:0] ea;
        if (reset) begin
            exp_q.delete();
            addr_q.delete();
            rd_issued  = 0;
            acc        = 0;
            prev_stall = 0;
            prev_tv    = 0;
        end else begin
            if (m_mem_rd) begin
                chk((rd_issued - acc) < FD, "credit", 64'(rd_issued - acc), FD - 1);
                if (addr_q.size() == 0) chk(0, "unexpected_read", m_mem_addr, 0);
                else begin
                    ea = addr_q.pop_front();
                    chk(m_mem_addr == ea, "read_addr", m_mem_addr, ea);
                end
                rd_issued++;
            end
            if (prev_stall)
                chk(tvalid && ({tlast, tdata} == prev_beat), "stall_hold",
                    {tvalid, tlast, tdata}, {1'b1, prev_beat});
            if (tvalid && !prev_tv) tv_rise = cyc;
            if (done) chk(last_tl_cyc == cyc - 1, "done_after_tlast", 64'(cyc - last_tl_cyc), 1);
            if (tvalid && tready) begin
                if (exp_q.size() == 0) chk(0, "unexpected_beat", {tlast, tdata}, 0);
                else begin
                    e = exp_q.pop_front();
                    chk({tlast, tdata} == e, "beat", {tlast, tdata}, e);
                end
                acc++;
                if (tlast) last_tl_cyc = cyc;
            end
            prev_stall = tvalid && !tready;
            prev_tv    = tvalid;
            prev_beat  = {tlast, tdata};
        end
    end

    task automatic run(input logic [AW-1:0] sa, input logic [3:0] w, input logic [3:0] h,
                       input int beats, input bit rnd, input bit timing, output logic [31:0] cs);
        int            n0;
        int            dcyc;
        bit            got;
        bit            busy_at_done;
        logic [AW-1:0] a;
        for (int i = 0; i < beats; i++) begin
            a = sa + AW'(i);
            exp_q.push_back({(i == beats - 1), mem_word(a)});
            addr_q.push_back(a);
        end
        tr_rand = rnd;
        cs = '0;
        @(posedge aclk); #1;
        start = 1'b1; startAddr = sa; tw = w; th = h;
        @(posedge aclk); #1;
        n0 = cyc;
        start = 1'b0;
        @(negedge aclk);
        chk(busy && m_mem_rd && (m_mem_addr == sa), "first_read",
            {busy, m_mem_rd, m_mem_addr}, {2'b11, sa});
        got = 0; dcyc = 0; busy_at_done = 1;
        for (int k = 0; k < 2000 && !got; k++) begin
            @(negedge aclk);
            if (done) begin
                got = 1;
                dcyc = cyc;
                busy_at_done = busy;
`ifdef TEXTURE_STREAM_TX_CHECKSUM_EN
                cs = checksum;
`endif
            end
        end
        chk(got, "done_seen", 64'(got), 1);
        if (got) begin
            chk(!busy_at_done, "busy_low_at_done", 64'(busy_at_done), 0);
            chk(exp_q.size() == 0, "all_beats", 64'(exp_q.size()), 0);
            if (timing) begin
                chk(dcyc == n0 + beats + 2, "done_cycle", 64'(dcyc - n0 + 1), 64'(beats + 3));
                chk(tv_rise == n0 + 2, "first_tvalid_cycle", 64'(tv_rise - n0 + 1), 3);
            end
        end
        tr_rand = 0;
    endtask

    initial begin
        logic [31:0] cs;
        bit          got;
        bit          seen;
        reset = 1'b1; start = 1'b0; startAddr = '0; tw = '0; th = '0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk(!busy, "rst_busy", 64'(busy), 0);
        chk(!done, "rst_done", 64'(done), 0);
        chk(!m_mem_rd, "rst_rd", 64'(m_mem_rd), 0);
        chk(m_mem_addr == '0, "rst_addr", m_mem_addr, 0);
        chk(!tvalid, "rst_tvalid", 64'(tvalid), 0);
        chk(!tlast, "rst_tlast", 64'(tlast), 0);
        chk(tdata == '0, "rst_tdata", tdata, 0);
        @(posedge aclk); #1;
        reset = 1'b0;

        run(17'h00100, 4'd2, 4'd2, 8,   0, 1, cs);   // 4x4
        run(17'h02000, 4'd0, 4'd0, 1,   0, 1, cs);   // 1x1, single tlast beat
        run(17'h00300, 4'd3, 4'd3, 32,  1, 0, cs);   // 8x8 with back-pressure
        run(17'h1FFFE, 4'd1, 4'd2, 4,   0, 1, cs);   // address wrap
        run(17'h00800, 4'd9, 4'd0, 128, 0, 1, cs);   // width field clamped to 8

        // Restart attempt while busy, then reset mid-stream.
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({(i == 7), mem_word(17'h00040 + AW'(i))});
            addr_q.push_back(17'h00040 + AW'(i));
        end
        @(posedge aclk); #1;
        start = 1'b1; startAddr = 17'h00040; tw = 4'd2; th = 4'd2;
        @(posedge aclk); #1;
        start = 1'b0;
        @(posedge aclk); #1;
        start = 1'b1; startAddr = 17'h00500; tw = 4'd0; th = 4'd0;
        @(posedge aclk); #1;
        start = 1'b0;
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge aclk); #1;
            if (acc >= 5) got = 1;
        end
        chk(got, "reach_beat5", 64'(acc), 5);
        @(posedge aclk); #1;
        reset = 1'b1;
        @(posedge aclk); #1;
        reset = 1'b0;
        @(negedge aclk);
        chk(!tvalid && !busy, "idle_after_reset", {tvalid, busy}, 0);
        seen = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge aclk);
            if (done) seen = 1;
        end
        chk(!seen, "no_done_after_reset", 64'(seen), 0);
        run(17'h00040, 4'd2, 4'd2, 8, 0, 1, cs);

`ifdef TEXTURE_STREAM_TX_CHECKSUM_EN
        small_mode = 1;
        small_base = 17'h00050;
        run(17'h00050, 4'd1, 4'd1, 2, 0, 1, cs);
        chk(cs == 32'd3, "checksum", cs, 3);
        small_mode = 0;
`endif

        repeat (3) @(negedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
